// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types and Gray-step classification for the quadrature decoder.
package quad_pkg;

  typedef logic [1:0] quad_state_t;

  typedef enum logic {
    INIT,
    TRACK
  } quad_fsm_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } quad_step_t;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; any other single-bit change is reverse.
  function automatic quad_step_t quad_decode(input quad_state_t prev, input quad_state_t cur);
    quad_step_t step;
    step = STEP_NONE;
    if (prev != cur) begin
      if ((prev ^ cur) == 2'b11) begin
        step = STEP_ILLEGAL;
      end else begin
        case ({prev, cur})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: step = STEP_FWD;
          default:                            step = STEP_REV;
        endcase
      end
    end
    return step;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - per-channel 2-flop synchronizer with optional stability filter.
// Filter compiled in by QUADRATURE_DECODER_FILTER_EN.
module quad_input_filter
`ifdef QUADRATURE_DECODER_FILTER_EN
  #(
    parameter int FILTER_CYCLES = 4
  )
`endif
  (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
  );

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef QUADRATURE_DECODER_FILTER_EN
  localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       acc_q, acc_d;

  // The accepted value moves only after FILTER_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (sync2_q == acc_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == CNT_LAST) begin
      acc_d = sync2_q;
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign dout = acc_q;
`else
  assign dout = sync2_q;
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - quadrature step decoder with position, direction and error count.
// Optional input glitch filter enabled by QUADRATURE_DECODER_FILTER_EN.
module quadrature_decoder #(
  parameter int POS_WIDTH     = 32,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 pos_clear,
  output logic                 state_change,
  output logic                 direction,
  output logic [POS_WIDTH-1:0] position,
  output logic                 error,
  output logic [15:0]          error_count
);
  import quad_pkg::*;

`ifdef QUADRATURE_DECODER_FILTER_EN
  localparam int SETTLE = 2 + FILTER_CYCLES;
`else
  localparam int SETTLE = 2;
`endif
  localparam int SETTLE_W = $clog2(2 + FILTER_CYCLES + 1);

  logic        a_acc, b_acc;
  quad_state_t cur;

`ifdef QUADRATURE_DECODER_FILTER_EN
  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk(clk), .reset(reset), .din(enc_a), .dout(a_acc)
  );
  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk(clk), .reset(reset), .din(enc_b), .dout(b_acc)
  );
`else
  quad_input_filter u_filt_a (
    .clk(clk), .reset(reset), .din(enc_a), .dout(a_acc)
  );
  quad_input_filter u_filt_b (
    .clk(clk), .reset(reset), .din(enc_b), .dout(b_acc)
  );
`endif

  assign cur = {a_acc, b_acc};

  quad_fsm_t             state_q, state_d;
  quad_state_t           prev_q, prev_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic                  state_change_q, state_change_d;
  logic                  direction_q, direction_d;
  logic [POS_WIDTH-1:0]  position_q, position_d;
  logic                  error_q, error_d;
  logic [15:0]           error_count_q, error_count_d;
  quad_step_t            step;

  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    settle_d       = settle_q;
    state_change_d = 1'b0;
    direction_d    = direction_q;
    position_d     = position_q;
    error_d        = 1'b0;
    error_count_d  = error_count_q;
    step           = quad_decode(prev_q, cur);

    case (state_q)
      INIT: begin
        // Sample cur one edge after SETTLE so the synchronizer/filter output has fully propagated.
        if (settle_q == SETTLE_W'(SETTLE)) begin
          prev_d  = cur;
          state_d = TRACK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      TRACK: begin
        prev_d = cur;
        case (step)
          STEP_FWD: begin
            position_d     = position_q + POS_WIDTH'(1);
            direction_d    = 1'b1;
            state_change_d = 1'b1;
          end
          STEP_REV: begin
            position_d     = position_q - POS_WIDTH'(1);
            direction_d    = 1'b0;
            state_change_d = 1'b1;
          end
          STEP_ILLEGAL: begin
            error_d = 1'b1;
            if (error_count_q != 16'hFFFF) begin
              error_count_d = error_count_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
      default: state_d = INIT;
    endcase

    if (pos_clear) begin
      position_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= INIT;
      prev_q         <= 2'b00;
      settle_q       <= '0;
      state_change_q <= 1'b0;
      direction_q    <= 1'b0;
      position_q     <= '0;
      error_q        <= 1'b0;
      error_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      settle_q       <= settle_d;
      state_change_q <= state_change_d;
      direction_q    <= direction_d;
      position_q     <= position_d;
      error_q        <= error_d;
      error_count_q  <= error_count_d;
    end
  end

  assign state_change = state_change_q;
  assign direction    = direction_q;
  assign position     = position_q;
  assign error        = error_q;
  assign error_count  = error_count_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - scoreboard bench for quadrature_decoder.
module tb_quadrature_decoder;

  localparam int FC = 4;
`ifdef QUADRATURE_DECODER_FILTER_EN
  localparam int LAT = 3 + FC;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        reset;
  logic        enc_a;
  logic        enc_b;
  logic        pos_clear;
  logic        state_change;
  logic        direction;
  logic [31:0] position;
  logic        error;
  logic [15:0] error_count;

  quadrature_decoder #(.POS_WIDTH(32), .FILTER_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .pos_clear(pos_clear),
    .state_change(state_change), .direction(direction), .position(position),
    .error(error), .error_count(error_count)
  );

  typedef struct {
    bit          is_err;
    logic        dir;
    logic [31:0] pos;
    logic [15:0] ecnt;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          n_sc = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [1:0]  exp_prev;
  logic [31:0] exp_pos;
  logic        exp_dir;
  logic [15:0] exp_ecnt;
  int          sc0, er0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Position of each pin state along the forward Gray sequence.
  function automatic int gray_idx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Drive a new pin state, predict the resulting pulse and hold for `hold` cycles.
  // With clr set, pos_clear is raised for exactly the edge that decodes the step.
  task automatic drive(input logic [1:0] ab, input int hold, input bit clr);
    int d;
    exp_t x;
    @(negedge clk);
    enc_a = ab[1];
    enc_b = ab[0];
    if (ab != exp_prev) begin
      d = (gray_idx(ab) - gray_idx(exp_prev) + 4) % 4;
      x.is_err = 1'b0;
      if (d == 1) begin
        exp_pos = clr ? 32'd0 : exp_pos + 32'd1;
        exp_dir = 1'b1;
      end else if (d == 3) begin
        exp_pos = clr ? 32'd0 : exp_pos - 32'd1;
        exp_dir = 1'b0;
      end else begin
        x.is_err = 1'b1;
        if (exp_ecnt != 16'hFFFF) exp_ecnt = exp_ecnt + 16'd1;
      end
      x.dir  = exp_dir;
      x.pos  = exp_pos;
      x.ecnt = exp_ecnt;
      x.at   = cyc + LAT;
      sb.push_back(x);
    end
    exp_prev = ab;
    for (int i = 1; i < hold; i++) begin
      pos_clear = (clr && i == LAT);
      @(negedge clk);
    end
    pos_clear = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    reset = 1'b1;
    enc_a = ab[1];
    enc_b = ab[0];
    pos_clear = 1'b0;
    sb.delete();
    exp_prev = ab;
    exp_pos  = 32'd0;
    exp_dir  = 1'b0;
    exp_ecnt = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  // Monitor: every pulse pops the oldest prediction and is checked against it.
  initial forever begin
    @(negedge clk);
    if (!reset && (state_change || error)) begin
      n_sc += int'(state_change);
      n_err += int'(error);
      chk("pulse_exclusive", {31'd0, state_change & error}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got state_change=%0b error=%0b expected none (cycle %0d)",
                 state_change, error, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_error", {31'd0, error}, {31'd0, e.is_err});
        chk("pulse_cycle", cyc, e.at);
        chk("pulse_direction", {31'd0, direction}, {31'd0, e.dir});
        chk("pulse_position", position, e.pos);
        chk("pulse_error_count", {16'd0, error_count}, {16'd0, e.ecnt});
      end
    end
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    pos_clear = 1'b0;
    exp_prev = 2'b11;
    exp_pos = 32'd0;
    exp_dir = 1'b0;
    exp_ecnt = 16'd0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state_change", {31'd0, state_change}, 32'd0);
    chk("rst_direction", {31'd0, direction}, 32'd0);
    chk("rst_position", position, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_error_count", {16'd0, error_count}, 32'd0);

    // Static 11 through INIT: no pulses, position stays 0.
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("static11_pulses", n_sc + n_err, 0);
    chk("static11_position", position, 32'd0);

    // Forward full cycle.
    do_reset(2'b00);
    sc0 = n_sc;
    drive(2'b01, 10, 0);
    drive(2'b11, 10, 0);
    drive(2'b10, 10, 0);
    drive(2'b00, 10, 0);
    drain();
    chk("fwd_pulses", n_sc - sc0, 4);
    chk("fwd_position", position, 32'd4);
    chk("fwd_direction", {31'd0, direction}, 32'd1);
    chk("fwd_error_count", {16'd0, error_count}, 32'd0);

`ifdef QUADRATURE_DECODER_FILTER_EN
    // Glitch shorter than FILTER_CYCLES is rejected.
    sc0 = n_sc;
    er0 = n_err;
    @(negedge clk);
    enc_a = 1'b1;
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_pulses", (n_sc - sc0) + (n_err - er0), 0);
    chk("glitch_position", position, 32'd4);
`endif

    // Clear, then reverse full cycle from 0.
    @(negedge clk);
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    exp_pos = 32'd0;
    @(negedge clk);
    chk("clear_position", position, 32'd0);
    sc0 = n_sc;
    drive(2'b10, 10, 0);
    drive(2'b11, 10, 0);
    drive(2'b01, 10, 0);
    drive(2'b00, 10, 0);
    drain();
    chk("rev_pulses", n_sc - sc0, 4);
    chk("rev_position", position, 32'hFFFF_FFFC);
    chk("rev_direction", {31'd0, direction}, 32'd0);

    // Illegal 00 -> 11 jump.
    sc0 = n_sc;
    er0 = n_err;
    drive(2'b11, 10, 0);
    drain();
    chk("illegal_err_pulses", n_err - er0, 1);
    chk("illegal_sc_pulses", n_sc - sc0, 0);
    chk("illegal_error_count", {16'd0, error_count}, 32'd1);
    chk("illegal_position", position, 32'hFFFF_FFFC);

    // pos_clear coincident with a forward step 11 -> 10.
    drive(2'b10, 10, 1);
    drain();
    chk("clrstep_position", position, 32'd0);
    chk("clrstep_direction", {31'd0, direction}, 32'd1);

    // Wrap below zero and back.
    drive(2'b11, 10, 0);
    drain();
    chk("wrap_down_position", position, 32'hFFFF_FFFF);
    drive(2'b10, 10, 0);
    drain();
    chk("wrap_up_position", position, 32'd0);

    // Second illegal jump 10 -> 01.
    drive(2'b01, 10, 0);
    drain();
    chk("illegal2_error_count", {16'd0, error_count}, 32'd2);

`ifndef QUADRATURE_DECODER_FILTER_EN
    // Back-to-back illegal jumps every cycle, driving error_count into saturation.
    for (int i = 0; i < 65540; i++) begin
      drive((i % 2 == 0) ? 2'b10 : 2'b01, 1, 0);
    end
    drain();
    chk("sat_error_count", {16'd0, error_count}, 32'h0000_FFFF);
    chk("sat_position", position, 32'd0);
`endif

    // Two forward steps, then asynchronous reset mid-operation.
    drive(fwd_next(exp_prev), 10, 0);
    drive(fwd_next(exp_prev), 10, 0);
    drain();
    chk("pre_reset_position", position, 32'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_position", position, 32'd0);
    chk("midrst_error_count", {16'd0, error_count}, 32'd0);
    chk("midrst_direction", {31'd0, direction}, 32'd0);
    chk("midrst_state_change", {31'd0, state_change}, 32'd0);
    chk("midrst_error", {31'd0, error}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Converts raw two-channel quadrature encoder pins into a single-cycle `state_change` strobe, a direction flag and a signed position count. It sits directly upstream of the tick timer in the BLDC velocity path: `state_change` is the tick the timer measures, and `direction` and `position` feed the velocity and position loops. Illegal transitions, where both channels change at once, are flagged and counted rather than silently absorbed.

## Interface
Parameters:
- POS_WIDTH, 32, width of the signed position counter.
- FILTER_CYCLES, 4, consecutive stable cycles a channel needs before it is accepted. Only used when the filter is compiled in. Range 1..255.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enc_a  input  1  encoder channel A, asynchronous to clk.
- enc_b  input  1  encoder channel B, asynchronous to clk.
- pos_clear  input  1  synchronous clear of `position`, sampled each cycle.
- state_change  output  1  one-cycle pulse per legal quadrature step.
- direction  output  1  1 = forward, 0 = reverse; reflects the last legal step.
- position  output  POS_WIDTH  signed step count, two's complement.
- error  output  1  one-cycle pulse per illegal transition.
- error_count  output  16  count of illegal transitions; saturates at 16'hFFFF.

## Operation
- Each channel passes through a 2-flop synchronizer, reset to 0.
- The accepted state is `cur = {A,B}`, taken from the synchronizer output or from the filter output when the filter is compiled in.
- The forward Gray sequence is 00→01→11→10→00. The reverse sequence is the opposite order.
- FSM states are INIT and TRACK.
- INIT:
  - Entered on reset.
  - Waits SETTLE cycles. SETTLE = 2, or 2+FILTER_CYCLES with the filter.
  - Then loads `prev <= cur` and moves to TRACK.
  - Produces no `state_change`, no `error` and no position change.
- TRACK, evaluated every cycle:
  - cur == prev: no action; outputs hold.
  - Forward step: position+1, direction<=1, state_change pulse.
  - Reverse step: position−1, direction<=0, state_change pulse.
  - Both bits differ: error pulse; error_count+1 (saturating); position, direction and state_change unchanged.
  - `prev <= cur` in all cases.
- Position arithmetic is modulo 2^POS_WIDTH and wraps silently. 0x7FFFFFFF+1 gives 0x80000000. 0−1 gives 0xFFFFFFFF.
- pos_clear:
  - When set, position <= 0 that cycle.
  - pos_clear wins over a simultaneous step.
  - The `state_change` and `direction` updates for that step still occur.
- An asserted reset mid-operation returns the block to INIT immediately, with all outputs at their reset values.

## Timing
- Reset values: state_change 0, direction 0, position 0, error 0, error_count 0, FSM INIT, prev 00.
- Latency from the first clk edge that samples a pin change to the output pulse:
  - 3 edges without the filter.
  - 3+FILTER_CYCLES edges with the filter.
- state_change and error:
  - Each is high for exactly one cycle per event.
  - They are never high in the same cycle.
- Back-to-back steps on consecutive accepted samples produce pulses on consecutive cycles; there is no minimum spacing.
- direction, position and error_count update on the same edge that raises the corresponding pulse.

## Configuration
- Macro: QUADRATURE_DECODER_FILTER_EN.
- Defined:
  - Each synchronized channel drives a stability counter.
  - The accepted channel value changes only after the synchronized value differs from it for FILTER_CYCLES consecutive cycles.
  - The counter resets whenever the synchronized value matches the accepted value.
  - Pulses shorter than FILTER_CYCLES cycles are rejected.
- Undefined: `cur` is the synchronizer output directly. FILTER_CYCLES is ignored.

## Structure
- Package `quad_pkg`:
  - typedef `quad_state_t` (logic [1:0]).
  - enum `quad_fsm_t` {INIT, TRACK}.
  - typedef `quad_step_t` {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL}.
  - Function `quad_decode(prev, cur)` returning `quad_step_t`.
- Sub-module `quad_input_filter`:
  - Contains the per-channel synchronizer plus the optional stability counter.
  - Instantiated once for A and once for B.
  - Parameterized by FILTER_CYCLES.

## Test plan
- Reset with enc_a=1, enc_b=1 held static → after INIT: no state_change, no error, position stays 0.
- Forward sequence 00→01→11→10→00, each state held 10 cycles → four state_change pulses, position=4, direction=1, error_count=0.
- Reverse full cycle starting from position 0 → position=0xFFFFFFFC, direction=0, four pulses.
- 00→11 jump → one error pulse, error_count=1, position unchanged, no state_change. Forcing error_count to 0xFFFF then adding one more illegal jump leaves it at 0xFFFF.
- pos_clear asserted on the same cycle a forward step is decoded → position=0, state_change=1, direction=1.
- With QUADRATURE_DECODER_FILTER_EN and FILTER_CYCLES=4:
  - A 3-cycle glitch on enc_a → no response.
  - A stable step → state_change 7 edges after the pin change is first sampled.
